// File: rtl/multi_source_switch.sv
// N-channel break-before-make source switcher with synchronised select and registered data path.
// Optional 16-bit completed-switch counter: define MULTI_SOURCE_SWITCH_COUNT_EN.
module multi_source_switch #(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEAD_CYCLES = 3,
  localparam int SEL_WIDTH  = $clog2(NUM_SOURCES)
) (
  input  logic                              i_Clock,
  input  logic                              reset,
  input  logic [SEL_WIDTH-1:0]              i_Selected_Source,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] i_Channel_Data,
  input  logic [NUM_SOURCES-1:0]            i_Channel_Valid,
  output logic [NUM_SOURCES-1:0]            o_Enable,
  output logic [SEL_WIDTH-1:0]              o_Active_Source,
  output logic                              o_Switch_Busy,
  output logic [DATA_WIDTH-1:0]             o_Output_Data,
  output logic                              o_Data_Valid
`ifdef MULTI_SOURCE_SWITCH_COUNT_EN
  ,
  output logic [15:0]                       o_Switch_Count
`endif
);

  localparam logic [0:0] ST_ACTIVE = 1'b0;
  localparam logic [0:0] ST_GAP    = 1'b1;

  localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [NUM_SOURCES-1:0] EN_RESET = {{(NUM_SOURCES-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0][SEL_WIDTH-1:0] r_sync;
  logic [0:0]                            r_state;
  logic [SEL_WIDTH-1:0]                  r_target;
  logic [CNT_W-1:0]                      r_gap_cnt;

  logic [SEL_WIDTH-1:0]   w_sel_s;
  logic                   w_sel_ok;
  logic                   w_start;
  logic                   w_relatch;
  logic                   w_done;
  logic [NUM_SOURCES-1:0] w_onehot;
  logic                   w_act_valid;
  logic [DATA_WIDTH-1:0]  w_act_data;

  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_Selected_Source};
    end
  end

  assign w_sel_s  = r_sync[SYNC_STAGES-1];
  assign w_sel_ok = ({{(32-SEL_WIDTH){1'b0}}, w_sel_s} < 32'(NUM_SOURCES));

  assign w_start   = (r_state == ST_ACTIVE) && w_sel_ok && (w_sel_s != o_Active_Source);
  assign w_relatch = (r_state == ST_GAP) && (r_gap_cnt == '0) && w_sel_ok && (w_sel_s != r_target);
  assign w_done    = (r_state == ST_GAP) && (r_gap_cnt == '0) && !w_relatch;

  always_comb begin
    w_onehot           = '0;
    w_onehot[r_target] = 1'b1;
  end

  assign w_act_valid = i_Channel_Valid[o_Active_Source];
  assign w_act_data  = i_Channel_Data[o_Active_Source*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_ACTIVE;
      r_target        <= '0;
      r_gap_cnt       <= '0;
      o_Active_Source <= '0;
      o_Enable        <= EN_RESET;
      o_Switch_Busy   <= 1'b0;
    end else if (w_start || w_relatch) begin
      r_target      <= w_sel_s;
      r_gap_cnt     <= GAP_LOAD;
      o_Enable      <= '0;
      o_Switch_Busy <= 1'b1;
      r_state       <= ST_GAP;
    end else if (w_done) begin
      o_Active_Source <= r_target;
      o_Enable        <= w_onehot;
      o_Switch_Busy   <= 1'b0;
      r_state         <= ST_ACTIVE;
    end else if (r_state == ST_GAP) begin
      r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  // The edge that drops the enable already counts as gap, so the old channel's
  // final word is not forwarded alongside the switch.
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      o_Output_Data <= '0;
      o_Data_Valid  <= 1'b0;
    end else if ((r_state == ST_ACTIVE) && !w_start) begin
      o_Data_Valid <= w_act_valid;
      if (w_act_valid) begin
        o_Output_Data <= w_act_data;
      end
    end else begin
      o_Data_Valid <= 1'b0;
    end
  end

`ifdef MULTI_SOURCE_SWITCH_COUNT_EN
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      o_Switch_Count <= '0;
    end else if (w_done) begin
      o_Switch_Count <= o_Switch_Count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_source_switch.sv
// Self-checking bench for multi_source_switch: directed scenarios plus a randomised run
// against a deadline-based behavioural model of the switching rules.
module tb_multi_source_switch;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int DC = 3;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [SW-1:0]    sel;
  logic [NS*DW-1:0] cdata;
  logic [NS-1:0]    cvalid;
  logic [NS-1:0]    en;
  logic [SW-1:0]    act;
  logic             busy;
  logic [DW-1:0]    odata;
  logic             odv;

  logic [1:0]       sel3;
  logic [3*DW-1:0]  cdata3;
  logic [2:0]       cvalid3;
  logic [2:0]       en3;
  logic [1:0]       act3;
  logic             busy3;
  logic [DW-1:0]    odata3;
  logic             odv3;
`ifdef MULTI_SOURCE_SWITCH_COUNT_EN
  logic [15:0]      cnt;
  logic [15:0]      cnt3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_source_switch #(.NUM_SOURCES(NS), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .DEAD_CYCLES(DC)) dut (
    .i_Clock(clk), .reset(rst), .i_Selected_Source(sel), .i_Channel_Data(cdata),
    .i_Channel_Valid(cvalid), .o_Enable(en), .o_Active_Source(act), .o_Switch_Busy(busy),
    .o_Output_Data(odata), .o_Data_Valid(odv)
`ifdef MULTI_SOURCE_SWITCH_COUNT_EN
    , .o_Switch_Count(cnt)
`endif
  );

  multi_source_switch #(.NUM_SOURCES(3), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .DEAD_CYCLES(DC)) dut3 (
    .i_Clock(clk), .reset(rst), .i_Selected_Source(sel3), .i_Channel_Data(cdata3),
    .i_Channel_Valid(cvalid3), .o_Enable(en3), .o_Active_Source(act3), .o_Switch_Busy(busy3),
    .o_Output_Data(odata3), .o_Data_Valid(odv3)
`ifdef MULTI_SOURCE_SWITCH_COUNT_EN
    , .o_Switch_Count(cnt3)
`endif
  );

  // Behavioural model: select samples delayed by a queue, dead time as an absolute deadline.
  int          m_q[$];
  bit          m_busy;
  int          m_active;
  int          m_target;
  int          m_resume;
  bit          m_dv;
  logic [DW-1:0] m_data;
  int          m_count;
  int          cyc = 0;

  task automatic model_reset();
    m_q.delete();
    repeat (SS) m_q.push_back(0);
    m_busy = 0; m_active = 0; m_target = 0; m_resume = 0;
    m_dv = 0; m_data = '0; m_count = 0;
  endtask

  task automatic tick();
    int ss;
    int s_sel;
    logic [NS-1:0]    v;
    logic [NS*DW-1:0] d;
    s_sel = int'(sel);
    v = cvalid;
    d = cdata;
    ss = m_q[0];
    @(posedge clk);
    cyc++;
    if (!m_busy) begin
      if (ss < NS && ss != m_active) begin
        m_busy = 1; m_target = ss; m_resume = cyc + DC; m_dv = 0;
      end else begin
        m_dv = v[m_active];
        if (m_dv) m_data = d[m_active*DW +: DW];
      end
    end else begin
      m_dv = 0;
      if (cyc >= m_resume) begin
        if (ss < NS && ss != m_target) begin
          m_target = ss; m_resume = cyc + DC;
        end else begin
          m_active = m_target; m_busy = 0; m_count = (m_count + 1) % 65536;
        end
      end
    end
    m_q.push_back(s_sel);
    void'(m_q.pop_front());
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sel = '0;
    sel3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (en !== 4'b0001 || act !== 2'd0 || busy !== 1'b0 || odata !== 8'h00 || odv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: en=%b act=%0d busy=%b data=%h dv=%b, required en=0001 act=0 busy=0 data=00 dv=0",
               en, act, busy, odata, odv);
    end
    do_reset();
    cdata  = 32'h5A3C_77A5;
    cvalid = 4'b0001;
    tick();
    n_checks++;
    if (en !== 4'b0001 || act !== 2'd0 || odv !== 1'b1 || odata !== 8'hA5) begin
      n_fail++;
      $display("FAIL first_data: en=%b act=%0d dv=%b data=%h, required en=0001 act=0 dv=1 data=a5",
               en, act, odv, odata);
    end
  endtask

  task automatic test_switch();
    logic [NS-1:0] exp_en;
    logic          exp_busy;
    cvalid = 4'b1111;
    sel = 2'd2;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_en   = (e < 3) ? 4'b0001 : ((e < 6) ? 4'b0000 : 4'b0100);
      exp_busy = (e >= 3 && e < 6);
      n_checks++;
      if (en !== exp_en || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL switch_ctrl edge %0d: en=%b busy=%b, required en=%b busy=%b", e, en, busy, exp_en, exp_busy);
      end
      if (e >= 3 && e <= 6) begin
        n_checks++;
        if (odv !== 1'b0) begin
          n_fail++;
          $display("FAIL switch_gap_valid edge %0d: dv=%b, required 0", e, odv);
        end
      end
    end
    n_checks++;
    if (odv !== 1'b1 || odata !== 8'h3C || act !== 2'd2) begin
      n_fail++;
      $display("FAIL switch_new_data: dv=%b data=%h act=%0d, required dv=1 data=3c act=2", odv, odata, act);
    end
  endtask

  task automatic test_relatch();
    int  zeros = 0;
    bit  saw_ch1 = 0;
    sel = 2'd1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) sel = 2'd3;
      if (en == 4'b0000) zeros++;
      if (en == 4'b0010) saw_ch1 = 1;
      if (e == 9) begin
        n_checks++;
        if (en !== 4'b1000) begin
          n_fail++;
          $display("FAIL relatch_enable edge 9: en=%b, required 1000", en);
        end
      end
    end
    n_checks++;
    if (zeros < 4 || saw_ch1 || act !== 2'd3) begin
      n_fail++;
      $display("FAIL relatch_gap: zero_cycles=%0d saw_ch1=%0d act=%0d, required >=4, 0, 3", zeros, saw_ch1, act);
    end
  endtask

  task automatic test_glitch();
    sel = 2'd0;
    #2 sel = 2'd3;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_checks++;
      if (en !== 4'b1000 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch edge %0d: en=%b busy=%b, required en=1000 busy=0", e, en, busy);
      end
    end
  endtask

  task automatic test_out_of_range();
    sel3 = 2'd3;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_checks++;
      if (en3 !== 3'b001 || busy3 !== 1'b0 || act3 !== 2'd0) begin
        n_fail++;
        $display("FAIL oor_ignored edge %0d: en=%b busy=%b act=%0d, required en=001 busy=0 act=0", e, en3, busy3, act3);
      end
    end
    sel3 = 2'd2;
    repeat (6) tick();
    n_checks++;
    if (en3 !== 3'b100 || act3 !== 2'd2 || odv3 !== 1'b0 || odata3 !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_valid_switch: en=%b act=%0d dv=%b data=%h, required en=100 act=2 dv=0 data=00",
               en3, act3, odv3, odata3);
    end
`ifdef MULTI_SOURCE_SWITCH_COUNT_EN
    n_checks++;
    if (cnt3 !== 16'd1) begin
      n_fail++;
      $display("FAIL oor_count: count=%0d, required 1", cnt3);
    end
`endif
  endtask

  task automatic test_reset_gap();
    sel = 2'd1;
    repeat (4) tick();
    n_checks++;
    if (en !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_gap_pre: en=%b busy=%b, required en=0000 busy=1", en, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (en !== 4'b0001 || busy !== 1'b0 || odv !== 1'b0 || act !== 2'd0 || odata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_gap_async: en=%b busy=%b dv=%b act=%0d data=%h, required 0001 0 0 0 00",
               en, busy, odv, act, odata);
    end
    do_reset();
  endtask

  task automatic test_count();
`ifdef MULTI_SOURCE_SWITCH_COUNT_EN
    int seq[5] = '{1, 2, 3, 0, 1};
    do_reset();
    foreach (seq[i]) begin
      sel = SW'(seq[i]);
      repeat (8) tick();
    end
    n_checks++;
    if (cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL count_five: count=%0d, required 5", cnt);
    end
    sel = 2'd2;
    repeat (3) tick();
    sel = 2'd3;
    repeat (10) tick();
    n_checks++;
    if (cnt !== 16'd6 || en !== 4'b1000) begin
      n_fail++;
      $display("FAIL count_relatch: count=%0d en=%b, required 6 1000", cnt, en);
    end
`endif
  endtask

  task automatic test_random();
    int hold;
    logic [NS-1:0] exp_en;
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 3) != 0) sel = SW'($urandom_range(0, NS-1));
      hold = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) begin
        cvalid = NS'($urandom);
        cdata  = $urandom;
        if ($urandom_range(0, 9) == 0) begin
          logic [SW-1:0] keep;
          keep = sel;
          sel = SW'($urandom);
          #2 sel = keep;
        end
        tick();
        exp_en = m_busy ? '0 : (NS'(1) << m_active);
        n_checks++;
        if (en !== exp_en || act !== SW'(m_active) || busy !== m_busy) begin
          n_fail++;
          $display("FAIL random_ctrl cyc %0d: en=%b act=%0d busy=%b, required en=%b act=%0d busy=%b",
                   cyc, en, act, busy, exp_en, m_active, m_busy);
        end
        n_checks++;
        if (odv !== m_dv || odata !== m_data) begin
          n_fail++;
          $display("FAIL random_data cyc %0d: dv=%b data=%h, required dv=%b data=%h", cyc, odv, odata, m_dv, m_data);
        end
`ifdef MULTI_SOURCE_SWITCH_COUNT_EN
        n_checks++;
        if (cnt !== 16'(m_count)) begin
          n_fail++;
          $display("FAIL random_count cyc %0d: count=%0d, required %0d", cyc, cnt, m_count);
        end
`endif
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    sel     = '0;
    cdata   = '0;
    cvalid  = '0;
    sel3    = '0;
    cdata3  = 24'h112233;
    cvalid3 = '0;
    model_reset();
    test_reset();
    test_switch();
    test_relatch();
    test_glitch();
    test_out_of_range();
    test_reset_gap();
    test_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
